// File: rtl/sensor_display_gate.sv
// sensor_display_gate: merges DS18B20 temperature and MAX30102 heart-rate/SpO2
// results into one snapshot and issues a rate-limited, change-only redraw
// strobe (sensor_done) to the OLED controller. Published values stay stable
// until the next publish.
// Optional build macro: SENSOR_RANGE_CLAMP_EN clamps sensor values on capture.
module sensor_display_gate #(
    parameter int unsigned MIN_INTERVAL_CYC = 25_000_000,
    parameter int unsigned ACK_TIMEOUT_CYC  = 50_000_000,
    parameter int unsigned CNT_W            = 26
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       temp_done,
    input  logic [7:0] temp_int_in,
    input  logic [7:0] temp_deci_in,
    input  logic       hr_valid,
    input  logic [7:0] heart_rate_in,
    input  logic [7:0] spo2_in,
    input  logic       disp_ready,
    output logic       sensor_done,
    output logic [7:0] temp_int,
    output logic [7:0] temp_deci,
    output logic [7:0] heart_rate,
    output logic [7:0] spo2,
    output logic       ack_timeout
);

    typedef enum logic [1:0] {S_WAIT, S_PUB, S_BUSY, S_DONE} state_e;

    localparam logic [CNT_W-1:0] IntervalMax = CNT_W'(MIN_INTERVAL_CYC);
    // Timeout counter is 0 in the publish cycle, so the last waiting cycle is N-1.
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(ACK_TIMEOUT_CYC - 1);

    state_e           state_q, state_d;
    logic [7:0]       sh_temp_int_q, sh_temp_deci_q, sh_hr_q, sh_spo2_q;
    logic [7:0]       sh_temp_int_d, sh_temp_deci_d, sh_hr_d, sh_spo2_d;
    logic [7:0]       temp_int_d, temp_deci_d, heart_rate_d, spo2_d;
    logic             dirty_q, dirty_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             go_pub, timeout_fire, expired, timed_out;
    logic [7:0]       temp_deci_cl, hr_cl, spo2_cl;

`ifdef SENSOR_RANGE_CLAMP_EN
    // Below 30 bpm is reported as 0, meaning "no pulse".
    assign hr_cl        = (heart_rate_in < 8'd30)  ? 8'd0   :
                          (heart_rate_in > 8'd220) ? 8'd220 : heart_rate_in;
    assign spo2_cl      = (spo2_in > 8'd100)      ? 8'd100 : spo2_in;
    assign temp_deci_cl = (temp_deci_in > 8'd9)   ? 8'd9   : temp_deci_in;
`else
    assign hr_cl        = heart_rate_in;
    assign spo2_cl      = spo2_in;
    assign temp_deci_cl = temp_deci_in;
`endif

    assign expired   = (icnt_q == IntervalMax);
    assign timed_out = (tcnt_q >= TimeoutLast);

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_WAIT;
        else        state_q <= state_d;
    end

    // Next-state logic, publish decision and timeout detection
    always_comb begin
        state_d      = state_q;
        go_pub       = 1'b0;
        timeout_fire = 1'b0;
        unique case (state_q)
            S_WAIT: begin
                if (dirty_q && expired && disp_ready) begin
                    state_d = S_PUB;
                    go_pub  = 1'b1;
                end
            end
            S_PUB:  state_d = S_BUSY;
            S_BUSY: begin
                if (!disp_ready) begin
                    state_d = S_DONE;
                end else if (timed_out) begin
                    state_d      = S_WAIT;
                    timeout_fire = 1'b1;
                end
            end
            S_DONE: begin
                if (disp_ready) begin
                    state_d = S_WAIT;
                end else if (timed_out) begin
                    state_d      = S_WAIT;
                    timeout_fire = 1'b1;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    // Next shadows, outputs, dirty flag and counters
    always_comb begin
        sh_temp_int_d  = sh_temp_int_q;
        sh_temp_deci_d = sh_temp_deci_q;
        sh_hr_d        = sh_hr_q;
        sh_spo2_d      = sh_spo2_q;
        if (temp_done) begin
            sh_temp_int_d  = temp_int_in;
            sh_temp_deci_d = temp_deci_cl;
        end
        if (hr_valid) begin
            sh_hr_d   = hr_cl;
            sh_spo2_d = spo2_cl;
        end
        // Outputs take the shadows as they stand before this cycle's capture.
        temp_int_d   = go_pub ? sh_temp_int_q  : temp_int;
        temp_deci_d  = go_pub ? sh_temp_deci_q : temp_deci;
        heart_rate_d = go_pub ? sh_hr_q        : heart_rate;
        spo2_d       = go_pub ? sh_spo2_q      : spo2;
        // Shadows only change on capture, so this is "captured data differs from
        // what is (or is about to be) published".
        dirty_d = ({sh_temp_int_d, sh_temp_deci_d, sh_hr_d, sh_spo2_d} !=
                   {temp_int_d, temp_deci_d, heart_rate_d, spo2_d});
        icnt_d = icnt_q;
        if (go_pub)             icnt_d = '0;
        else if (!expired)      icnt_d = icnt_q + 1'b1;
        tcnt_d = tcnt_q;
        if (go_pub)                         tcnt_d = '0;
        else if (state_q != S_WAIT && !timed_out) tcnt_d = tcnt_q + 1'b1;
    end

    // Shadow, dirty and counter registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_temp_int_q  <= '0;
            sh_temp_deci_q <= '0;
            sh_hr_q        <= '0;
            sh_spo2_q      <= '0;
            dirty_q        <= 1'b0;
            icnt_q         <= IntervalMax;
            tcnt_q         <= '0;
        end else begin
            sh_temp_int_q  <= sh_temp_int_d;
            sh_temp_deci_q <= sh_temp_deci_d;
            sh_hr_q        <= sh_hr_d;
            sh_spo2_q      <= sh_spo2_d;
            dirty_q        <= dirty_d;
            icnt_q         <= icnt_d;
            tcnt_q         <= tcnt_d;
        end
    end

    // Published outputs and strobes; values and sensor_done change on the same edge
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            temp_int    <= '0;
            temp_deci   <= '0;
            heart_rate  <= '0;
            spo2        <= '0;
            sensor_done <= 1'b0;
            ack_timeout <= 1'b0;
        end else begin
            temp_int    <= temp_int_d;
            temp_deci   <= temp_deci_d;
            heart_rate  <= heart_rate_d;
            spo2        <= spo2_d;
            sensor_done <= go_pub;
            ack_timeout <= timeout_fire;
        end
    end

endmodule

// File: tb/tb_sensor_display_gate.sv
// Testbench for sensor_display_gate: scoreboard of expected publishes with
// latency windows, plus directed checks for rate limiting, change detection,
// ack timeout, held disp_ready, reset mid-redraw and optional clamping.
module tb_sensor_display_gate;

    localparam int unsigned MinIv = 16;
    localparam int unsigned AckTo = 64;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       temp_done = 1'b0;
    logic [7:0] temp_int_in = '0;
    logic [7:0] temp_deci_in = '0;
    logic       hr_valid = 1'b0;
    logic [7:0] heart_rate_in = '0;
    logic [7:0] spo2_in = '0;
    logic       disp_ready = 1'b1;
    logic       sensor_done, ack_timeout;
    logic [7:0] temp_int, temp_deci, heart_rate, spo2;

    sensor_display_gate #(
        .MIN_INTERVAL_CYC(MinIv),
        .ACK_TIMEOUT_CYC (AckTo),
        .CNT_W           (8)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .temp_done    (temp_done),
        .temp_int_in  (temp_int_in),
        .temp_deci_in (temp_deci_in),
        .hr_valid     (hr_valid),
        .heart_rate_in(heart_rate_in),
        .spo2_in      (spo2_in),
        .disp_ready   (disp_ready),
        .sensor_done  (sensor_done),
        .temp_int     (temp_int),
        .temp_deci    (temp_deci),
        .heart_rate   (heart_rate),
        .spo2         (spo2),
        .ack_timeout  (ack_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] ti;
        logic [7:0] td;
        logic [7:0] hr;
        logic [7:0] sp;
        int         lo;
        int         hi;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   to_cnt = 0;
    int   to_last = -1;
    logic sd_prev = 1'b0;
    logic disp_auto = 1'b1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic expect_pub(input logic [7:0] ti, td, hr, sp, input int lo, hi);
        exp_t x;
        x.ti = ti; x.td = td; x.hr = hr; x.sp = sp; x.lo = lo; x.hi = hi;
        sb_q.push_back(x);
    endtask

    task automatic drive_temp(input logic [7:0] ti, td);
        temp_int_in = ti; temp_deci_in = td; temp_done = 1'b1;
        tick(1);
        temp_done = 1'b0;
    endtask

    task automatic drive_hr(input logic [7:0] hr, sp);
        heart_rate_in = hr; spo2_in = sp; hr_valid = 1'b1;
        tick(1);
        hr_valid = 1'b0;
    endtask

    // Monitor: pop expectations on every strobe, count timeouts
    always @(negedge sys_clk) begin
        if (rst_n) begin
            if (ack_timeout) begin
                to_cnt++;
                to_last = cyc;
            end
            if (sensor_done) begin
                done_cnt++;
                if (sd_prev) check_eq("sd_width", sd_prev, 0);
                if (sb_q.size() == 0) begin
                    check_eq("sd_spurious", sensor_done, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("pub_temp_int", temp_int, e.ti);
                    check_eq("pub_temp_deci", temp_deci, e.td);
                    check_eq("pub_heart_rate", heart_rate, e.hr);
                    check_eq("pub_spo2", spo2, e.sp);
                    if (e.lo == e.hi) begin
                        check_eq("sd_cycle", cyc, e.lo);
                    end else begin
                        check_eq("sd_not_early", int'(cyc >= e.lo), 1);
                        check_eq("sd_not_late", int'(cyc <= e.hi), 1);
                    end
                end
            end
            sd_prev = sensor_done;
        end else begin
            sd_prev = 1'b0;
        end
    end

    // Display model: drop disp_ready briefly after each strobe
    initial begin
        forever begin
            @(negedge sys_clk);
            if (disp_auto && rst_n && sensor_done) begin
                disp_ready = 1'b0;
                repeat (4) @(negedge sys_clk);
                disp_ready = 1'b1;
            end
        end
    end

    initial begin
        int c, p, d0, t0, r;
        logic [7:0] hr_e, sp_e, hr2_e, td3_e;

        // Reset values
        tick(3);
        check_eq("rst_sensor_done", sensor_done, 0);
        check_eq("rst_temp_int", temp_int, 0);
        check_eq("rst_temp_deci", temp_deci, 0);
        check_eq("rst_heart_rate", heart_rate, 0);
        check_eq("rst_spo2", spo2, 0);
        check_eq("rst_ack_timeout", ack_timeout, 0);
        rst_n = 1'b1;
        tick(2);

        // First publish is not delayed: strobe at capture+2
        c = cyc;
        expect_pub(8'd25, 8'd3, 8'd0, 8'd0, c + 2, c + 2);
        drive_temp(8'd25, 8'd3);
        p = c + 2;

        // Rate limit: new HR data two cycles after publish waits for the interval
        tick(3);
        expect_pub(8'd25, 8'd3, 8'd72, 8'd98, p + MinIv, p + MinIv + 8);
        drive_hr(8'd72, 8'd98);
        tick(30);

        // Identical captures publish nothing
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) begin
            drive_temp(8'd25, 8'd3);
            tick(19);
        end
        check_eq("same_no_sd", done_cnt, d0);
        check_eq("same_temp_int", temp_int, 25);
        check_eq("same_temp_deci", temp_deci, 3);
        check_eq("same_heart_rate", heart_rate, 72);
        check_eq("same_spo2", spo2, 98);

        // Ack timeout: display never starts the redraw
        disp_auto = 1'b0;
        t0 = to_cnt;
        c = cyc;
        expect_pub(8'd26, 8'd0, 8'd72, 8'd98, c + 2, c + 2);
        drive_temp(8'd26, 8'd0);
        p = c + 2;
        tick(71);
        check_eq("to_count", to_cnt, t0 + 1);
        check_eq("to_cycle", to_last, p + AckTo);
        check_eq("to_hold_temp_int", temp_int, 26);
        // Back in S_WAIT: a new capture publishes again
        c = cyc;
        expect_pub(8'd27, 8'd1, 8'd72, 8'd98, c + 2, c + 2);
        drive_temp(8'd27, 8'd1);
        tick(2);
        disp_ready = 1'b0;
        tick(3);
        disp_ready = 1'b1;
        tick(5);
        check_eq("to_no_repeat", to_cnt, t0 + 1);

        // Both strobes together while the display is busy
        disp_ready = 1'b0;
        tick(20);
        d0 = done_cnt;
        temp_int_in = 8'd30; temp_deci_in = 8'd5; temp_done = 1'b1;
        heart_rate_in = 8'd80; spo2_in = 8'd97; hr_valid = 1'b1;
        tick(1);
        temp_done = 1'b0; hr_valid = 1'b0;
        tick(10);
        check_eq("busy_no_sd", done_cnt, d0);
        r = cyc;
        expect_pub(8'd30, 8'd5, 8'd80, 8'd97, r + 1, r + 1);
        disp_ready = 1'b1;
        tick(2);
        disp_ready = 1'b0;
        tick(3);
        disp_ready = 1'b1;
        tick(5);
        check_eq("both_single_sd", done_cnt, d0 + 1);
        disp_auto = 1'b1;
        tick(20);

        // Range handling (clamped or passed through depending on build)
`ifdef SENSOR_RANGE_CLAMP_EN
        hr_e = 8'd220; sp_e = 8'd100; hr2_e = 8'd0; td3_e = 8'd9;
`else
        hr_e = 8'd250; sp_e = 8'd120; hr2_e = 8'd10; td3_e = 8'd15;
`endif
        c = cyc;
        expect_pub(8'd30, 8'd5, hr_e, sp_e, c + 2, c + 2);
        drive_hr(8'd250, 8'd120);
        tick(25);
        c = cyc;
        expect_pub(8'd30, 8'd5, hr2_e, 8'd95, c + 2, c + 2);
        drive_hr(8'd10, 8'd95);
        tick(25);
        c = cyc;
        expect_pub(8'd30, td3_e, hr2_e, 8'd95, c + 2, c + 2);
        drive_temp(8'd30, 8'd15);
        tick(25);

        // Reset in the middle of a redraw
        c = cyc;
        expect_pub(8'd40, 8'd2, hr2_e, 8'd95, c + 2, c + 2);
        drive_temp(8'd40, 8'd2);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_temp_int", temp_int, 0);
        check_eq("midrst_heart_rate", heart_rate, 0);
        check_eq("midrst_sensor_done", sensor_done, 0);
        tick(6);
        rst_n = 1'b1;
        tick(2);
        // Shadows were lost; interval preloaded so no extra delay
        c = cyc;
        expect_pub(8'd41, 8'd0, 8'd0, 8'd0, c + 2, c + 2);
        drive_temp(8'd41, 8'd0);
        tick(30);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sensor_display_gate.md
Name: sensor_display_gate

Overview:
- Upstream stage of the OLED display controller. It merges the DS18B20 temperature results and the MAX30102 heart-rate/SpO2 results into one snapshot.
- It issues the single-cycle `sensor_done` strobe that triggers a data redraw on the OLED.
- It rate-limits redraws and publishes only when data changed.
- It holds the published values stable until the display has finished consuming them.

Parameters:
- MIN_INTERVAL_CYC, 25_000_000: minimum sys_clk cycles between two `sensor_done` pulses (0.5 s at 50 MHz).
- ACK_TIMEOUT_CYC, 50_000_000: maximum cycles to wait for the display to finish a redraw before giving up.
- CNT_W, 26: width of the interval and timeout counters. Must hold max(MIN_INTERVAL_CYC, ACK_TIMEOUT_CYC).

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- temp_done  in  1  one-cycle strobe; temp_int_in/temp_deci_in valid
- temp_int_in  in  8  temperature integer part
- temp_deci_in  in  8  temperature decimal part
- hr_valid  in  1  one-cycle strobe; heart_rate_in/spo2_in valid
- heart_rate_in  in  8  beats per minute
- spo2_in  in  8  SpO2 percent
- disp_ready  in  1  high while the display controller is idle and able to accept a redraw
- sensor_done  out  1  one-cycle redraw strobe to the display
- temp_int  out  8  published temperature integer part
- temp_deci  out  8  published temperature decimal part
- heart_rate  out  8  published heart rate
- spo2  out  8  published SpO2
- ack_timeout  out  1  one-cycle pulse when a redraw was not completed within ACK_TIMEOUT_CYC

Behaviour:
- Reset is rst_n: asynchronous, active-low. Clock is sys_clk.
- Reset values:
  - All outputs are 0.
  - Shadow registers are 0 and the dirty flag is 0.
  - The interval counter is preloaded to MIN_INTERVAL_CYC, so the first publish is not delayed.
  - The FSM is in S_WAIT.
- Capture:
  - On temp_done, the shadow temp registers load temp_int_in/temp_deci_in.
  - On hr_valid, the shadow HR registers load heart_rate_in/spo2_in.
  - Both strobes in the same cycle are both captured.
  - Capture happens in every FSM state.
- Dirty flag:
  - Set in the cycle after a capture whose value differs from the published output registers.
  - A capture of identical values does not set it.
  - Cleared on publish.
  - A capture in the publish cycle sets dirty again if it differs from the newly published values.
- Interval counter:
  - Increments every cycle and saturates at MIN_INTERVAL_CYC.
  - Cleared to 0 on publish.
  - "Interval expired" means counter == MIN_INTERVAL_CYC.
- FSM states:
  - S_WAIT:
    - When dirty && expired && disp_ready, go to S_PUB.
    - Otherwise stay. Captures keep updating the shadows, so only the latest value is published.
  - S_PUB (exactly 1 cycle):
    - Outputs load from the shadows and sensor_done = 1.
    - Clear dirty and the interval counter, clear the timeout counter, go to S_BUSY.
    - The output registers and sensor_done update together, so values are valid in the same cycle as the strobe.
  - S_BUSY:
    - Wait for disp_ready = 0 (redraw started), then go to S_DONE.
    - If ACK_TIMEOUT_CYC elapses first, pulse ack_timeout and go to S_WAIT.
  - S_DONE:
    - Wait for disp_ready = 1, then go to S_WAIT.
    - The same timeout rule applies; the counter continues from S_BUSY and is not restarted.
- Outputs stay stable from the S_PUB cycle until the next S_PUB.
- sensor_done is never asserted outside S_PUB.
- Latency: with dirty set, interval expired and disp_ready high, sensor_done asserts 2 cycles after the capture strobe (capture, then dirty evaluation, then S_PUB).
- Reset mid-redraw: outputs return to 0 immediately and the FSM returns to S_WAIT. Data captured before reset is lost.

Optional Feature:
- Macro SENSOR_RANGE_CLAMP_EN.
- When defined, shadow loads are clamped:
  - heart_rate to 30..220 (below 30 becomes 0, meaning "no pulse"; above 220 becomes 220);
  - spo2 to 0..100 (above 100 becomes 100);
  - temp_deci to 0..9.
- The dirty comparison uses the clamped values.
- When undefined, values pass through unmodified.

Test Plan:
- Interval elapsed, disp_ready=1; temp_done with 25/3 → sensor_done at capture+2, temp_int=25, temp_deci=3, others 0.
- MIN_INTERVAL_CYC=16: publish, then hr_valid 72/98 at +2 → next sensor_done no earlier than 16 cycles after the first, with heart_rate=72 and spo2=98.
- Identical temp_done 25/3 repeated every 20 cycles after a publish → no further sensor_done; outputs unchanged.
- ACK_TIMEOUT_CYC=64, disp_ready held 1 after publish → ack_timeout pulses at publish+64; FSM returns to S_WAIT; a new capture publishes again.
- temp_done and hr_valid in the same cycle (30/5, 80/97) with disp_ready=0 → no strobe; disp_ready rises → single sensor_done carrying all four values.
- With SENSOR_RANGE_CLAMP_EN defined: hr_valid 250/120 → heart_rate=220, spo2=100. hr_valid 10/95 → heart_rate=0.
